// File: rtl/hack_uart_loader.sv
// UART boot loader: receives an 8N1 byte stream, parses AA/LEN/words/CHK packets
// and writes 16-bit instruction words into the ROM while holding the CPU in reset.
module hack_uart_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ROM_DEPTH    = 32768
) (
  input  logic        CLK_100MHz,
  input  logic        reset,
  input  logic        UART_RX,
  output logic        rom_we,
  output logic [14:0] rom_addr,
  output logic [15:0] rom_data,
  output logic        cpu_reset,
  output logic        load_ok,
  output logic        load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      DEPTH_MAX = 17'(ROM_DEPTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;

  logic             rx_meta, rx_sync, rx_prev;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_stb, frame_err;

  logic [2:0]       state;
  logic [7:0]       len_hi;
  logic [15:0]      len;
  logic [15:0]      word_cnt;
  logic [7:0]       checksum;

  // NOTE: the synchronizer resets to the idle-high level so a reset release
  // can never look like a falling edge, i.e. a false start bit.
  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // updates from pre-edge values regardless of statement order.
  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      rx_state  <= RX_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            clk_cnt  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            rx_byte <= {rx_sync, rx_byte[7:1]};
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt   <= '0;
            rx_state  <= RX_IDLE;
            byte_stb  <= rx_sync;
            frame_err <= !rx_sync;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHz) begin
    if (reset) begin
      state     <= S_IDLE;
      len_hi    <= '0;
      len       <= '0;
      word_cnt  <= '0;
      checksum  <= '0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_data  <= '0;
      cpu_reset <= 1'b0;
      load_ok   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      rom_we    <= 1'b0;
      // Registered from the current state, so it drops one cycle after IDLE is reached.
      cpu_reset <= (state != S_IDLE);
      if (rom_we) rom_addr <= rom_addr + 15'd1;

      if (byte_stb) begin
        case (state)
          S_IDLE, S_ERROR: begin
            if (rx_byte == 8'hAA) begin
              state    <= S_LEN_HI;
              load_ok  <= 1'b0;
              load_err <= 1'b0;
              checksum <= '0;
              rom_addr <= '0;
              word_cnt <= '0;
            end
          end
          S_LEN_HI: begin
            len_hi <= rx_byte;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len <= {len_hi, rx_byte};
            if ({len_hi, rx_byte} == 16'd0)                 state <= S_CHECK;
            else if ({1'b0, len_hi, rx_byte} > DEPTH_MAX)   state <= S_ERROR;
            else                                            state <= S_DATA_HI;
          end
          S_DATA_HI: begin
            rom_data[15:8] <= rx_byte;
            checksum       <= checksum + rx_byte;
            state          <= S_DATA_LO;
          end
          S_DATA_LO: begin
            rom_data[7:0] <= rx_byte;
            checksum      <= checksum + rx_byte;
            rom_we        <= 1'b1;
            word_cnt      <= word_cnt + 16'd1;
            state         <= (word_cnt + 16'd1 == len) ? S_CHECK : S_DATA_HI;
          end
          S_CHECK: begin
            if (rx_byte == checksum) begin
              load_ok <= 1'b1;
              state   <= S_IDLE;
            end else begin
              load_err <= 1'b1;
              state    <= S_ERROR;
            end
          end
          default: state <= S_ERROR;
        endcase
      end else if (frame_err && state != S_IDLE) begin
        load_err <= 1'b1;
        state    <= S_ERROR;
      end
    end
  end

endmodule

// File: tb/tb_hack_uart_loader.sv
// Randomized self-checking bench for hack_uart_loader: serializes packets onto
// UART_RX and compares ROM writes and status flags with a packet-level model.
module tb_hack_uart_loader;

  localparam int CPB    = 4;
  localparam int SETTLE = 6 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_data;
  logic        cpu_reset;
  logic        load_ok;
  logic        load_err;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [30:0] wr_q_t[$];

  int checks   = 0;
  int failures = 0;

  logic [30:0] wr_q[$];
  logic        we_prev = 1'b0;
  logic        cr_seen = 1'b0;

  hack_uart_loader #(.CLKS_PER_BIT(CPB), .ROM_DEPTH(32768)) dut (
    .CLK_100MHz(clk),
    .reset     (reset),
    .UART_RX   (rx),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .cpu_reset (cpu_reset),
    .load_ok   (load_ok),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe mid-cycle; a strobe must never last two cycles.
  always @(negedge clk) begin
    if (rom_we) begin
      wr_q.push_back({rom_addr, rom_data});
      check("we_width", {31'd0, we_prev}, 32'd0);
    end
    we_prev = rom_we;
    if (cpu_reset) cr_seen = 1'b1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop;
    wait_cycles(CPB);
    rx = 1'b1;
  endtask

  task automatic send_bytes(input byte_q_t bytes, input int max_gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      if (max_gap > 0) wait_cycles($urandom_range(max_gap, 0));
    end
  endtask

  // Packet-level model: the words land at consecutive addresses from 0 and
  // the checksum is the mod-256 sum of the data bytes.
  function automatic logic [7:0] data_sum(input logic [15:0] words[$]);
    logic [7:0] s = 8'd0;
    foreach (words[i]) s = s + words[i][15:8] + words[i][7:0];
    return s;
  endfunction

  function automatic byte_q_t build_packet(input logic [15:0] words[$], input logic [7:0] chk);
    byte_q_t p;
    logic [15:0] n = 16'(words.size());
    p.push_back(8'hAA);
    p.push_back(n[15:8]);
    p.push_back(n[7:0]);
    foreach (words[i]) begin
      p.push_back(words[i][15:8]);
      p.push_back(words[i][7:0]);
    end
    p.push_back(chk);
    return p;
  endfunction

  function automatic wr_q_t expected_writes(input logic [15:0] words[$]);
    wr_q_t q;
    foreach (words[i]) q.push_back({15'(i), words[i]});
    return q;
  endfunction

  task automatic expect_writes(input string tag, input wr_q_t exp);
    check({tag, "_count"}, wr_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_q.size(); i++)
      check(tag, {1'b0, wr_q[i]}, {1'b0, exp[i]});
    wr_q.delete();
  endtask

  task automatic expect_status(input string tag, input logic ok, input logic err, input logic cr);
    check({tag, "_ok"},  {31'd0, load_ok},   {31'd0, ok});
    check({tag, "_err"}, {31'd0, load_err},  {31'd0, err});
    check({tag, "_cpu"}, {31'd0, cpu_reset}, {31'd0, cr});
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, "_we"},   {31'd0, rom_we}, 32'd0);
    check({tag, "_addr"}, {17'd0, rom_addr}, 32'd0);
    check({tag, "_data"}, {16'd0, rom_data}, 32'd0);
    expect_status(tag, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_good_empty(input string tag);
    byte_q_t p;
    logic [15:0] none[$];
    p = build_packet(none, 8'h00);
    send_bytes(p, 0);
    wait_cycles(SETTLE);
    expect_writes(tag, expected_writes(none));
    expect_status(tag, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] words[$];
    byte_q_t     pkt;
    logic [7:0]  chk;
    int          k;
    int          n;
    logic        bad;

    reset = 1'b1;
    rx    = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);
    expect_reset_values("por");

    // Two-word load; the CHK byte is the mod-256 sum 12+34+AB+CD = 0xBE.
    words = '{16'h1234, 16'hABCD};
    chk   = data_sum(words);
    check("sum_ref", {24'd0, chk}, 32'h0000_00BE);
    pkt   = build_packet(words, chk);
    send_bytes(pkt[0:2], 0);
    check("cpu_mid", {31'd0, cpu_reset}, 32'd1);
    send_bytes(pkt[3:$], 0);
    k = 0;
    while (!load_ok && k < 4 * CPB) begin
      @(negedge clk);
      k++;
    end
    check("ok_wait", {31'd0, load_ok}, 32'd1);
    check("cpu_hold", {31'd0, cpu_reset}, 32'd1);
    @(negedge clk);
    check("cpu_drop", {31'd0, cpu_reset}, 32'd0);
    expect_writes("two_word", expected_writes(words));
    expect_status("two_word", 1'b1, 1'b0, 1'b0);

    // Checksum mismatch: the word stays written, loader lands in ERROR.
    send_bytes('{8'hAA, 8'h00, 8'h01, 8'h00, 8'h05, 8'h06}, 0);
    wait_cycles(SETTLE);
    expect_writes("bad_chk", '{{15'd0, 16'h0005}});
    expect_status("bad_chk", 1'b0, 1'b1, 1'b1);

    // Empty load out of ERROR.
    run_good_empty("from_err");

    // Oversized length: ERROR without load_err, and further bytes are not data.
    send_bytes('{8'hAA, 8'h80, 8'h01}, 0);
    wait_cycles(SETTLE);
    expect_status("len_err", 1'b0, 1'b0, 1'b1);
    send_bytes('{8'h12, 8'h34, 8'h56, 8'h78}, 0);
    wait_cycles(SETTLE);
    expect_writes("len_err", '{});
    run_good_empty("after_len");

    // Runt start pulse, then AA with a bad stop bit while IDLE.
    cr_seen = 1'b0;
    rx = 1'b0;
    wait_cycles(CPB / 4);
    rx = 1'b1;
    wait_cycles(3 * CPB);
    send_byte(8'hAA, 1'b0);
    wait_cycles(3 * CPB);
    check("glitch_cpu", {31'd0, cr_seen}, 32'd0);
    expect_status("glitch", 1'b1, 1'b0, 1'b0);
    run_good_empty("after_glitch");

    // Reset in the middle of the DATA_LO byte.
    send_bytes('{8'hAA, 8'h00, 8'h01, 8'h12}, 0);
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = (8'h34 >> i) & 8'h01;
      wait_cycles(CPB);
    end
    reset = 1'b1;
    rx    = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(12 * CPB);
    expect_writes("mid_reset", '{});
    expect_reset_values("mid_reset");
    words = '{16'(($urandom))};
    send_bytes(build_packet(words, data_sum(words)), 0);
    wait_cycles(SETTLE);
    expect_writes("post_reset", expected_writes(words));
    expect_status("post_reset", 1'b1, 1'b0, 1'b0);

    // Randomized loads, some with corrupted checksums and idle gaps.
    for (int t = 0; t < 10; t++) begin
      words.delete();
      n = $urandom_range(5, 1);
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      bad = ($urandom_range(3, 0) == 0);
      chk = data_sum(words) + (bad ? 8'($urandom_range(255, 1)) : 8'd0);
      send_bytes(build_packet(words, chk), $urandom_range(3, 0));
      wait_cycles(SETTLE);
      expect_writes($sformatf("rand%0d", t), expected_writes(words));
      expect_status($sformatf("rand%0d", t), !bad, bad, bad);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
